// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared constants, FSM state encoding and helpers for the
//            16-requester round-robin arbiter.
// Contents : NUM_REQ  - number of requesters
//            ID_W     - width of a requester index
//            HOLD_W   - width of the grant hold counter
//            arb_state_t - arbiter FSM states
//            id_to_onehot() - index to one-hot conversion
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int ID_W    = 4;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/grant_encoder.sv
`default_nettype none
// ============================================================================
// Module   : grant_encoder
// Purpose  : Converts a one-hot grant vector into the binary index of its set
//            bit. Any vector that is not exactly one-hot (including all-zero)
//            encodes to index 0.
// Ports    : onehot_vec [NUM_REQ-1:0] in  - one-hot grant vector
//            index      [ID_W-1:0]    out - binary index of the set bit
// Revision : 1.0 - initial release
// ============================================================================
module grant_encoder
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot_vec,
  output logic [ID_W-1:0]    index
);

  logic [ID_W-1:0] w_or_index;
  logic            w_is_onehot;

  // OR-ing the indices of all set bits is exact only for one-hot input;
  // the validity check below forces everything else to zero.
  always_comb begin
    w_or_index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (onehot_vec[i]) begin
        w_or_index = w_or_index | ID_W'(i);
      end
    end
  end

  // A vector is one-hot when it is non-zero and clearing its lowest set bit
  // leaves nothing behind.
  assign w_is_onehot = (onehot_vec != '0) &&
                       ((onehot_vec & (onehot_vec - NUM_REQ'(1))) == '0);

  assign index = w_is_onehot ? w_or_index : '0;

endmodule : grant_encoder
`default_nettype wire

// File: rtl/req_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module   : req_arbiter_16
// Purpose  : 16-requester round-robin arbiter with a bounded hold time.
//            A grant is held until the owner pulses done, drops its request,
//            or has held the grant for HOLD_MAX cycles (forced release, which
//            raises timeout for one cycle). Every grant is followed by one
//            idle cycle with grant=0 before the next grant appears.
// Params   : HOLD_MAX - maximum grant hold in cycles (legal range 1..255)
// Ports    : clk         in  - clock, rising edge
//            reset_n     in  - asynchronous active-low reset
//            req   [15:0] in  - request levels, bit i = requester i
//            done         in  - release pulse from the current owner
//            grant [15:0] out - registered one-hot grant, zero when idle
//            grant_id [3:0] out - index of the granted requester (0 if none)
//            grant_valid  out - high when grant is non-zero
//            timeout      out - one-cycle pulse on forced release
// Revision : 1.0 - initial release
// ============================================================================
module req_arbiter_16
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] c_hold_max = HOLD_W'(HOLD_MAX);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_grant_valid;
  logic                r_timeout;
  logic [ID_W-1:0]     r_last_id;
  logic [HOLD_W-1:0]   r_hold_cnt;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [ID_W-1:0]     w_grant_id;
  logic [ID_W-1:0]     w_cand;
  logic [ID_W-1:0]     w_win_id;
  logic                w_win_found;
  logic                w_req_dropped;
  logic                w_hold_expired;
  logic                w_release;
  logic                w_timeout_cause;

  grant_encoder u_grant_encoder (
    .onehot_vec (r_grant),
    .index      (w_grant_id)
  );

  // Round-robin search: start one past the last winner and walk upward,
  // wrapping 15->0. The 4-bit addition wraps naturally, so when only the
  // last winner is requesting the search ends back on it.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = r_last_id + ID_W'(k) + ID_W'(1);
      if (!w_win_found && req[w_cand]) begin
        w_win_found = 1'b1;
        w_win_id    = w_cand;
      end
    end
  end

  assign w_req_dropped   = !req[w_grant_id];
  assign w_hold_expired  = (r_hold_cnt == c_hold_max);
  assign w_release       = done || w_req_dropped || w_hold_expired;
  // A normal release takes precedence over the hold limit when both occur
  // in the same cycle, so timeout only flags a genuinely forced release.
  assign w_timeout_cause = w_hold_expired && !done && !w_req_dropped;

  // --------------------------------------------------------------------------
  // FSM and registered outputs
  // --------------------------------------------------------------------------
  // The RELEASE cycle is the mandatory zero-grant gap. Arbitration is done
  // on the edge that closes it (as well as from IDLE), so a waiting requester
  // sees its grant right after that single gap cycle; with no requests the
  // FSM falls back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_hold_cnt    <= '0;
      r_last_id     <= ID_W'(NUM_REQ - 1);
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RELEASE: begin
          if (w_win_found) begin
            r_state       <= ST_BUSY;
            r_grant       <= id_to_onehot(w_win_id);
            r_grant_valid <= 1'b1;
            r_last_id     <= w_win_id;
            r_hold_cnt    <= HOLD_W'(1);
          end else begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_hold_cnt    <= '0;
          end
        end

        ST_BUSY: begin
          if (w_release) begin
            r_state       <= ST_RELEASE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_hold_cnt    <= '0;
            r_timeout     <= w_timeout_cause;
          end else begin
            r_hold_cnt    <= r_hold_cnt + HOLD_W'(1);
          end
        end

        default: begin
          r_state       <= ST_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_hold_cnt    <= '0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_id    = w_grant_id;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule : req_arbiter_16
`default_nettype wire

// File: tb/tb_req_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_arbiter_16
// Purpose  : Self-checking bench for req_arbiter_16. A HOLD_MAX=4 instance
//            runs a table of directed vectors plus rotation and asynchronous
//            reset sequences; a default (HOLD_MAX=15) instance checks the
//            default hold limit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_arbiter_16;

  logic        clk;
  logic        reset_n;
  logic [15:0] req;
  logic        done;

  logic [15:0] grant4,  grant15;
  logic [3:0]  id4,     id15;
  logic        valid4,  valid15;
  logic        to4,     to15;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [15:0] exp_grant;
    logic [3:0]  exp_id;
    logic        exp_to;
  } vec_t;

  vec_t vecs[$];

  req_arbiter_16 #(.HOLD_MAX(4)) dut4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .done        (done),
    .grant       (grant4),
    .grant_id    (id4),
    .grant_valid (valid4),
    .timeout     (to4)
  );

  req_arbiter_16 dut15 (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .done        (done),
    .grant       (grant15),
    .grant_id    (id15),
    .grant_valid (valid15),
    .timeout     (to15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] r, input logic d, input logic [15:0] g,
                     input logic [3:0] id, input logic to);
    vecs.push_back('{req: r, done: d, exp_grant: g, exp_id: id, exp_to: to});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    done    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    done    = 1'b0;

    // ------------------------------------------------------------------
    // Reset state
    // ------------------------------------------------------------------
    tick();
    tick();
    check("reset grant",   32'(grant4), 32'h0);
    check("reset id",      32'(id4),    32'h0);
    check("reset valid",   32'(valid4), 32'h0);
    check("reset timeout", 32'(to4),    32'h0);
    reset_n = 1'b1;

    // ------------------------------------------------------------------
    // Directed vector table, HOLD_MAX=4 instance. Each row: inputs applied,
    // one clock edge, outputs after that edge.
    // ------------------------------------------------------------------
    add(16'h8001, 0, 16'h0001, 4'd0,  0); // 0: first search from 0
    add(16'h8001, 1, 16'h0000, 4'd0,  0); // 1: done -> release gap
    add(16'h8001, 0, 16'h8000, 4'd15, 0); // 2: next search from 1 -> 15
    add(16'h8001, 0, 16'h8000, 4'd15, 0); // 3: hold 2
    add(16'h8000, 0, 16'h8000, 4'd15, 0); // 4: hold 3
    add(16'h0000, 0, 16'h0000, 4'd0,  0); // 5: req drop -> release
    add(16'h0000, 0, 16'h0000, 4'd0,  0); // 6: back to idle
    add(16'h0000, 0, 16'h0000, 4'd0,  0); // 7: idle
    add(16'h0008, 0, 16'h0008, 4'd3,  0); // 8: grant 3
    add(16'h0208, 0, 16'h0008, 4'd3,  0); // 9: req[9] toggles, no change
    add(16'h0008, 0, 16'h0008, 4'd3,  0); // 10
    add(16'h0080, 0, 16'h0000, 4'd0,  0); // 11: req[3] dropped
    add(16'h0080, 0, 16'h0080, 4'd7,  0); // 12: grant 7, hold 1
    add(16'h0080, 0, 16'h0080, 4'd7,  0); // 13: hold 2
    add(16'h0080, 0, 16'h0080, 4'd7,  0); // 14: hold 3
    add(16'h0080, 0, 16'h0080, 4'd7,  0); // 15: hold 4
    add(16'h0080, 1, 16'h0000, 4'd0,  0); // 16: done at limit -> no timeout
    add(16'h0010, 0, 16'h0010, 4'd4,  0); // 17: grant 4, hold 1
    add(16'h0010, 0, 16'h0010, 4'd4,  0); // 18: hold 2
    add(16'h0010, 0, 16'h0010, 4'd4,  0); // 19: hold 3
    add(16'h0010, 0, 16'h0010, 4'd4,  0); // 20: hold 4
    add(16'h0010, 0, 16'h0000, 4'd0,  1); // 21: forced release
    add(16'h0010, 1, 16'h0010, 4'd4,  0); // 22: done in RELEASE ignored, re-grant 4
    add(16'h0010, 0, 16'h0010, 4'd4,  0); // 23: hold 2
    add(16'h0000, 0, 16'h0000, 4'd0,  0); // 24: release
    add(16'h0000, 1, 16'h0000, 4'd0,  0); // 25: idle, done ignored
    add(16'h0010, 1, 16'h0010, 4'd4,  0); // 26: done in IDLE ignored, grant 4
    add(16'h0010, 0, 16'h0010, 4'd4,  0); // 27: hold 2
    add(16'h0010, 0, 16'h0010, 4'd4,  0); // 28: hold 3
    add(16'h0010, 0, 16'h0010, 4'd4,  0); // 29: hold 4
    add(16'h0000, 0, 16'h0000, 4'd0,  0); // 30: req drop at limit -> no timeout

    foreach (vecs[i]) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      check($sformatf("v%0d grant", i),   32'(grant4), 32'(vecs[i].exp_grant));
      check($sformatf("v%0d id", i),      32'(id4),    32'(vecs[i].exp_id));
      check($sformatf("v%0d valid", i),   32'(valid4), 32'(vecs[i].exp_grant != 16'h0));
      check($sformatf("v%0d timeout", i), 32'(to4),    32'(vecs[i].exp_to));
    end

    // ------------------------------------------------------------------
    // Full rotation with all requesters active, done after 2 grant cycles.
    // ------------------------------------------------------------------
    do_reset();
    req = 16'hFFFF;
    for (int g = 0; g < 17; g++) begin
      tick();
      check($sformatf("rot%0d id a", g),    32'(id4),    32'(g % 16));
      check($sformatf("rot%0d grant a", g), 32'(grant4), 32'(32'h1 << (g % 16)));
      tick();
      check($sformatf("rot%0d id b", g),    32'(id4),    32'(g % 16));
      done = 1'b1;
      tick();
      done = 1'b0;
      check($sformatf("rot%0d gap", g),     32'(grant4), 32'h0);
    end

    // ------------------------------------------------------------------
    // Asynchronous reset mid-grant.
    // ------------------------------------------------------------------
    do_reset();
    req = 16'h0004;
    tick();
    check("areset pre id", 32'(id4), 32'd2);
    tick();
    req = 16'h0015;
    #2;
    reset_n = 1'b0;
    #1;
    check("areset grant",   32'(grant4), 32'h0);
    check("areset valid",   32'(valid4), 32'h0);
    check("areset id",      32'(id4),    32'h0);
    check("areset timeout", 32'(to4),    32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("areset post grant", 32'(grant4), 32'h0001);
    check("areset post id",    32'(id4),    32'd0);

    // ------------------------------------------------------------------
    // Default HOLD_MAX=15 instance: grant held 15 cycles, then forced out.
    // ------------------------------------------------------------------
    do_reset();
    req = 16'h0010;
    for (int c = 1; c <= 15; c++) begin
      tick();
      check($sformatf("h15 c%0d grant", c),   32'(grant15), 32'h0010);
      check($sformatf("h15 c%0d timeout", c), 32'(to15),    32'h0);
    end
    tick();
    check("h15 release grant", 32'(grant15), 32'h0);
    check("h15 timeout",       32'(to15),    32'h1);
    check("h15 release valid", 32'(valid15), 32'h0);
    tick();
    check("h15 regrant id",      32'(id15),    32'd4);
    check("h15 regrant timeout", 32'(to15),    32'h0);
    check("h15 regrant valid",   32'(valid15), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_req_arbiter_16
`default_nettype wire
